uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

Serial transmitter that consumes a VALID/READY byte stream and drives an asynchronous UART line: start bit, LSB-first data bits, optional parity, one or two stop bits. Sits directly downstream of the stream register slice, terminating the on-chip stream at the board's UART TX pin. Holds one byte internally. Deasserts READY for the whole frame, so upstream buffering absorbs backpressure.

## Interface
- `CLOCK_HZ`, 27_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame. Legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clock` input 1: single clock domain.
- `reset_n` input 1: reset. Asynchronous, active-low.
- `input_valid` input 1: upstream byte valid.
- `input_ready` output 1: high when the block accepts a byte this cycle.
- `input_data` input DATA_BITS: byte to send.
- `tx` output 1: UART line, registered, idle high.
- `busy` output 1: high while a frame is in progress.

## Operation
- Divider: `DIVIDER = (CLOCK_HZ + BAUD_RATE/2) / BAUD_RATE`, rounded to nearest. Elaboration error if DIVIDER < 2, or if any parameter is out of range.
- Baud counter width is `$clog2(DIVIDER)`. Each line bit lasts exactly DIVIDER clocks.
- States:
  - IDLE → START on handshake.
  - START → DATA after DIVIDER clocks.
  - DATA → PARITY (PARITY≠0) or STOP after DATA_BITS bit periods.
  - PARITY → STOP after DIVIDER clocks.
  - STOP → IDLE after STOP_BITS×DIVIDER clocks.
- `input_ready = (state == IDLE)`. It is combinational from state only and never depends on `input_valid`.
- Handshake (`input_valid && input_ready` at a rising edge):
  - `input_data` is latched into the shift register.
  - `tx` is driven to 0 at that same edge.
  - The baud counter is cleared.
- `input_data` is ignored outside the handshake cycle. Changes while busy have no effect.
- DATA state sends bit 0 first. The shift register shifts right once per bit period.
- Parity bit:
  - Even: `^data`.
  - Odd: `~^data`.
  - Parity is computed over the DATA_BITS latched bits.
- Stop bits drive `tx` = 1.
- `busy = (state != IDLE)`.
- Reset values: `tx` = 1, `busy` = 0, `input_ready` = 1 (state IDLE), counters 0, shift register 0.
- Handshakes during `reset_n` low are discarded.
- Reset mid-frame:
  - `tx` returns to 1 asynchronously and the frame is aborted. The partially sent byte is lost and not retried.
  - After `reset_n` rises, the next byte starts with a full start bit.

## Timing
- Latency: `tx` falls at the handshake edge, i.e. zero cycles after acceptance.
- Frame length: `FRAME = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS` bit periods.
- `input_ready` is low for exactly FRAME×DIVIDER clocks after the handshake edge, and high again in the following cycle.
- With `input_valid` held continuously, consecutive start-bit edges are FRAME×DIVIDER + 1 clocks apart. The extra clock is line-high (IDLE).
- Simultaneous events: ready is asserted only in IDLE, so no accept can coincide with frame end.
- `tx` is glitch-free, driven directly from a flop.

## Structure
- Package `uart_pkg` contains:
  - `uart_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Parity constants `PARITY_NONE/ODD/EVEN`.
  - Function `calc_divider(clock_hz, baud)`, shared with a future receiver.
- One sub-module, `uart_baud_counter`:
  - Clear input, enable input.
  - Emits a one-cycle `bit_done` pulse every DIVIDER clocks.
  - Async active-low reset.

## Test plan
All scenarios use CLOCK_HZ = 1_000_000 and BAUD_RATE = 100_000, giving DIVIDER = 10.
- Reset: hold `reset_n` low 5 cycles → `tx`=1, `busy`=0, `input_ready`=1. Valid pulses during reset produce no frame.
- 0x55, no parity, 1 stop → `tx` reads 0,1,0,1,0,1,0,1,0,1, each held 10 clocks. `input_ready` is low 100 clocks, then high.
- Back-to-back 0xA5 then 0x3C with `input_valid` held → second start-bit edge is 101 clocks after the first. Both bytes decode correctly in the scoreboard.
- PARITY=2 with 0x07 → parity bit 1. PARITY=1 with 0x07 → parity bit 0. In both, frame is 110 clocks and ready returns at clock 110.
- STOP_BITS=2 with 0x00 → `tx` low 90 clocks, then high 20 clocks. Ready returns after 110 clocks.
- Reset mid-frame: assert `reset_n` low during data bit 3 of 0xF0 → `tx`=1 and `busy`=0 without waiting for a clock edge. Then send 0x81 → correct full frame, with no residue of 0xF0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and the
// baud divider calculation used by both transmit and (future) receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Rounds to the nearest whole divider; a non-positive baud yields 0 so
    // the caller's range check reports it instead of dividing by zero.
    function automatic int calc_divider(input int clock_hz, input int baud);
        if (baud <= 0) begin
            return 0;
        end
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period timer: pulses o_bit_done on the last clock of
// every DIVIDER-clock period while enabled; i_clear restarts the period.
module uart_baud_counter #(
    parameter int DIVIDER = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIVIDER - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last  = (r_count == LAST_COUNT);
    assign o_bit_done = i_enable && w_at_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART transmitter: accepts one byte per frame over valid/ready and sends
// start, LSB-first data, optional parity and stop bits from a single flop.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    // Valid/ready: a byte transfers on any rising edge where input_valid and
    // input_ready are both high; ready depends on state only, never on valid.
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [DATA_BITS-1:0] input_data,
    output logic                 tx,
    output logic                 busy,
    output logic [2:0]           debug_state
);

    localparam int DIVIDER = calc_divider(CLOCK_HZ, BAUD_RATE);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);

    generate
        if (DIVIDER < 2) begin : g_bad_divider
            $error("uart_byte_tx: DIVIDER must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_byte_tx: DATA_BITS must be 5..9");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
            $error("uart_byte_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_byte_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [2:0]           r_state;
    logic                 r_tx;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_parity;

    logic                 w_accept;
    logic                 w_bit_done;
    logic                 w_enable;
    logic                 w_parity_in;

    assign input_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx          = r_tx;
    assign debug_state = r_state;

    assign w_accept    = input_valid && input_ready;
    assign w_enable    = (r_state != S_IDLE);
    assign w_parity_in = (PARITY == PARITY_EVEN) ? (^input_data) : (~^input_data);

    uart_baud_counter #(
        .DIVIDER (DIVIDER)
    ) u_baud (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_clear    (w_accept),
        .i_enable   (w_enable),
        .o_bit_done (w_bit_done)
    );

    // The start bit is driven at the accept edge itself, so every later bit
    // change lands on the bit_done edge that closes the previous period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_shift   <= input_data;
                        r_parity  <= w_parity_in;
                        r_tx      <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at DIVIDER = 10 across four parameter sets.
module tb_uart_byte_tx;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid_v;
  logic [7:0] data_a [4];
  wire  [3:0] tx_w;
  wire  [3:0] ready_w;
  wire  [3:0] busy_w;
  wire  [2:0] dbg0, dbg1, dbg2, dbg3;

  int checks;
  int errors;
  longint last_start_t;
  logic [7:0] exp_q[$];

  // Instance 0: no parity, 1 stop. 1: even. 2: odd. 3: no parity, 2 stop.
  uart_byte_tx #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .input_valid(valid_v[0]), .input_ready(ready_w[0]),
    .input_data(data_a[0]), .tx(tx_w[0]), .busy(busy_w[0]), .debug_state(dbg0));
  uart_byte_tx #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .input_valid(valid_v[1]), .input_ready(ready_w[1]),
    .input_data(data_a[1]), .tx(tx_w[1]), .busy(busy_w[1]), .debug_state(dbg1));
  uart_byte_tx #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .input_valid(valid_v[2]), .input_ready(ready_w[2]),
    .input_data(data_a[2]), .tx(tx_w[2]), .busy(busy_w[2]), .debug_state(dbg2));
  uart_byte_tx #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clock(clk), .reset_n(rst_n), .input_valid(valid_v[3]), .input_ready(ready_w[3]),
    .input_data(data_a[3]), .tx(tx_w[3]), .busy(busy_w[3]), .debug_state(dbg3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: wait for ready at a negedge, present the byte, return right after the accept edge
  task automatic send(input int idx, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w[idx] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_w[idx] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout dut%0d: ready=%b required 1", idx, ready_w[idx]);
    end
    valid_v[idx] = 1'b1;
    data_a[idx]  = d;
    exp_q.push_back(d);
    @(posedge clk);
  endtask

  // Checks one frame cycle by cycle starting at the negedge after the accept edge,
  // then the ready-return cycle; decoded data bits go to the scoreboard.
  task automatic check_frame(input string name, input int idx, input logic [7:0] d, input int par,
                             input int stops, input logic hold, input logic [7:0] next_d);
    int nbits;
    logic [11:0] exp_bits;
    logic [7:0] dec;
    logic [7:0] exp_d;
    logic p;
    nbits = 1 + 8 + ((par != 0) ? 1 : 0) + stops;
    p = (par == 2) ? ^d : ~^d;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
    if (par != 0) exp_bits[9] = p;
    dec = '0;
    for (int k = 0; k < nbits * DIV; k++) begin
      @(negedge clk);
      if (k == 0) last_start_t = $time;
      valid_v[idx] = hold;
      data_a[idx]  = 8'($urandom);
      checks++;
      if (tx_w[idx] !== exp_bits[k / DIV] || ready_w[idx] !== 1'b0 || busy_w[idx] !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d: tx=%b ready=%b busy=%b required tx=%b ready=0 busy=1",
                 name, k, tx_w[idx], ready_w[idx], busy_w[idx], exp_bits[k / DIV]);
      end
      if ((k % DIV) == 5 && (k / DIV) >= 1 && (k / DIV) <= 8) dec[(k / DIV) - 1] = tx_w[idx];
    end
    @(negedge clk);
    data_a[idx] = next_d;
    checks++;
    if (tx_w[idx] !== 1'b1 || ready_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_return at cycle %0d: tx=%b ready=%b busy=%b required tx=1 ready=1 busy=0",
               name, nbits * DIV, tx_w[idx], ready_w[idx], busy_w[idx]);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: decoded %h with empty expected queue", name, dec);
    end else begin
      exp_d = exp_q.pop_front();
      if (dec !== exp_d) begin
        errors++;
        $display("FAIL %s scoreboard: decoded %h required %h", name, dec, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_v = (c % 2 == 0) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
    end
    checks++;
    if (tx_w !== 4'hF || busy_w !== 4'h0 || ready_w !== 4'hF) begin
      errors++;
      $display("FAIL reset_values: tx=%b busy=%b ready=%b required tx=1111 busy=0000 ready=1111", tx_w, busy_w, ready_w);
    end
    valid_v = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) @(negedge clk);
    checks++;
    if (tx_w !== 4'hF || busy_w !== 4'h0 || dbg0 !== 3'd0 || dbg3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_no_frame: tx=%b busy=%b dbg0=%0d dbg3=%0d required tx=1111 busy=0000 idle", tx_w, busy_w, dbg0, dbg3);
    end
  endtask

  task automatic test_basic_55();
    send(0, 8'h55);
    check_frame("basic_55", 0, 8'h55, 0, 1, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    longint t1;
    longint t2;
    send(0, 8'hA5);
    check_frame("b2b_A5", 0, 8'hA5, 0, 1, 1'b1, 8'h3C);
    t1 = last_start_t;
    exp_q.push_back(8'h3C);
    check_frame("b2b_3C", 0, 8'h3C, 0, 1, 1'b0, 8'h00);
    t2 = last_start_t;
    checks++;
    if ((t2 - t1) / 10 != 101) begin
      errors++;
      $display("FAIL b2b_spacing: start edges %0d clocks apart, required 101", (t2 - t1) / 10);
    end
  endtask

  task automatic test_parity();
    send(1, 8'h07);
    check_frame("even_07", 1, 8'h07, 2, 1, 1'b0, 8'h00);
    send(2, 8'h07);
    check_frame("odd_07", 2, 8'h07, 1, 1, 1'b0, 8'h00);
  endtask

  task automatic test_two_stop();
    send(3, 8'h00);
    check_frame("stop2_00", 3, 8'h00, 0, 2, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    valid_v[0] = 1'b1;
    data_a[0]  = 8'hF0;
    @(posedge clk);
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      valid_v[0] = 1'b0;
    end
    checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_bit3: tx=%b busy=%b required tx=0 busy=1", tx_w[0], busy_w[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: tx=%b busy=%b ready=%b required tx=1 busy=0 ready=1", tx_w[0], busy_w[0], ready_w[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h81);
    check_frame("after_reset_81", 0, 8'h81, 0, 1, 1'b0, 8'h00);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    last_start_t = 0;
    rst_n   = 1'b0;
    valid_v = 4'h0;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
    test_reset();
    test_basic_55();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d bytes never decoded, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
